sequential_store: RTL and testbench
===================================

Name: sequential_store

Overview:
- Store-direction counterpart of the sequential load path.
- Accepts lane-entry-sized nibble buffers from the ShuffleUnit (already de-shuffled into memory order).
- Packs them into AXI W beats with byte strobes, driven per beat by the transaction-control stream (addr/head/final/last-nibble info).
- Sits between the ShuffleUnit and the AXI W channel of the VLSU.

Parameters:
- NR_LANES, 4, number of vector lanes.
- DLEN, 64, bits per lane entry.
- AXI_DATA_WIDTH, 128, W data width in bits.
- AXI_ADDR_WIDTH, 64, address width.
- Derived (not overridable): BUF_NBS = DLEN/4*NR_LANES; BUS_NBS = AXI_DATA_WIDTH/4; BNS = clog2(BUS_NBS); PW = clog2(BUF_NBS).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- rx_shfu_valid_i  in  1  buffer entry valid
- rx_shfu_ready_o  out  1  entry accepted
- rx_shfu_nb_i  in  BUF_NBS*4  entry nibbles, nibble i at [4i+:4]
- rx_shfu_en_i  in  BUF_NBS  per-nibble enable
- meta_valid_i  in  1  per-request start info valid
- meta_ready_o  out  1  meta consumed
- meta_nb_ptr_i  in  PW  first valid nibble in first entry
- txn_valid_i  in  1  per-beat control valid
- txn_ready_o  out  1  beat control consumed
- txn_addr_i  in  AXI_ADDR_WIDTH  beat address
- txn_is_head_i  in  1  first beat of burst
- txn_last_beat_i  in  1  last beat of burst (rmnBeat==0)
- txn_lbn_i  in  BNS+1  upper nibble bound of last beat
- txn_is_final_i  in  1  final beat of whole request
- w_valid_o  out  1  W beat valid
- w_ready_i  in  1  W beat accepted
- w_data_o  out  AXI_DATA_WIDTH  beat data
- w_strb_o  out  AXI_DATA_WIDTH/8  byte strobes
- w_last_o  out  1  = txn_last_beat_i of the emitted beat

Behaviour:
- Reset (rst_ni low, any time, including mid-request): FSM=S_IDLE. Entry holding reg empty; nb_ptr=0; bus_cnt=0; assembly reg and strobes zeroed. w_valid_o=0, w_data_o=0, w_strb_o=0, w_last_o=0. All ready outputs 0 during reset. Partial beats are discarded.
- Entry holding reg, 1 deep:
  - rx_shfu_ready_o = holding reg empty, or being released this cycle (same-cycle refill allowed).
- FSM S_IDLE -> S_PACK:
  - When txn_valid_i && meta_valid_i: nb_ptr <= meta_nb_ptr_i, bus_cnt <= 0, meta_ready_o=1 for that cycle.
  - meta_ready_o is 0 otherwise.
- S_PACK commit condition: holding reg full && txn_valid_i && W output slot free (w_valid_o=0, or w_ready_i=1 this cycle).
- Per commit:
  - lower = txn_is_head_i ? txn_addr_i[BNS-1:0] : 0
  - upper = txn_last_beat_i ? txn_lbn_i : BUS_NBS
  - bus_v = upper - lower - bus_cnt (BNS+1 bits)
  - buf_v = BUF_NBS - nb_ptr (PW+1 bits)
  - n = min(bus_v, buf_v)
  - Nibbles nb_ptr..nb_ptr+n-1 of the entry go to assembly nibbles lower+bus_cnt onward.
  - Assembly nibble enable = rx_shfu_en_i of the source nibble.
- Case bus_v > buf_v:
  - Release entry; nb_ptr <= 0; bus_cnt <= bus_cnt + n.
  - No W beat, no txn_ready_o.
- Case bus_v <= buf_v (beat complete):
  - txn_ready_o=1.
  - Assembly data plus this cycle's nibbles load into the W register: w_valid_o=1 next cycle.
  - Assembly reg cleared; bus_cnt <= 0; nb_ptr <= nb_ptr + n.
  - If bus_v == buf_v or txn_is_final_i: release entry, nb_ptr <= 0.
  - If txn_is_final_i: -> S_IDLE.
- Latency: a W beat is visible 1 cycle after its completing commit.
- w_data_o, w_strb_o and w_last_o hold stable while w_valid_o && !w_ready_i.
- w_strb_o[b] = en[2b] | en[2b+1].
- Byte alignment: lower and upper bounds must be even (byte-aligned). An odd bound in simulation triggers an $error. Disabled nibbles drive 0 data.
- Final beat with unused entry nibbles: the entry is still released, and the remaining nibbles are dropped.
- Simultaneous W handshake and new commit in the same cycle: the W register is reloaded, giving full throughput of 1 beat/cycle.

Optional Feature:
- Macro: SEQUENTIAL_STORE_BEAT_CNT_EN.
- When defined:
  - Adds output port beat_cnt_o, 32 bits, counting W handshakes (w_valid_o && w_ready_i). Wraps at 2^32.
  - Reset to 0; cleared on the cycle S_IDLE -> S_PACK.
- When undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Aligned, 1 entry, 2 beats (meta_nb_ptr=0, addr low=0, lbn=32, all en=1):
  - beat0 = entry nibbles 0-31, strb 0xFFFF, last=0.
  - beat1 = nibbles 32-63, last=1, final.
  - Entry released with beat1; FSM back to S_IDLE.
- Misaligned head (addr low nibble 4, head=1, single beat, last=1, lbn=32):
  - entry nibbles 0-27 appear at bus nibbles 4-31, strb 0xFFFC.
- Entry spanning (meta_nb_ptr=48, two entries queued):
  - beat0 nibbles 0-15 come from entry0[48:63], nibbles 16-31 from entry1[0:15].
  - rx_shfu_ready_o pulses to take entry1; nb_ptr ends at 16.
- Back-pressure (w_ready_i low 3 cycles after beat valid):
  - w_data_o and w_strb_o unchanged.
  - txn_ready_o stays 0 for the next beat until the slot frees.
  - No beat is lost or duplicated.
- Partial final beat (lbn=16, final=1, nb_ptr=0):
  - strb 0x00FF, w_last_o=1.
  - Entry released and nb_ptr=0.
  - Next request starts cleanly from new meta.
- Reset asserted mid-burst (after beat0 accepted):
  - All outputs 0 and FSM in S_IDLE.
  - With SEQUENTIAL_STORE_BEAT_CNT_EN defined, beat_cnt_o=0.

Source files
------------

// File: rtl/sequential_store.sv
// sequential_store: packs de-shuffled lane-entry nibble buffers into AXI W beats with byte strobes.
// Build macro SEQUENTIAL_STORE_BEAT_CNT_EN adds beat_cnt_o, a 32-bit count of W handshakes.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   rx_shfu_*             lane-entry stream from the ShuffleUnit (nibbles + per-nibble enables)
//   meta_*                per-request start nibble pointer into the first entry
//   txn_*                 per-beat control (address, head/last/final flags, last-beat upper bound)
//   w_*                   AXI W channel (data, byte strobes, last)
//   beat_cnt_o            W handshake counter, present only with SEQUENTIAL_STORE_BEAT_CNT_EN
module sequential_store #(
  parameter int unsigned NR_LANES       = 4,
  parameter int unsigned DLEN           = 64,
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned AXI_ADDR_WIDTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rx_shfu_valid_i,
  output logic                          rx_shfu_ready_o,
  input  logic [DLEN*NR_LANES-1:0]      rx_shfu_nb_i,
  input  logic [DLEN/4*NR_LANES-1:0]    rx_shfu_en_i,
  input  logic                          meta_valid_i,
  output logic                          meta_ready_o,
  input  logic [$clog2(DLEN/4*NR_LANES)-1:0] meta_nb_ptr_i,
  input  logic                          txn_valid_i,
  output logic                          txn_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]     txn_addr_i,
  input  logic                          txn_is_head_i,
  input  logic                          txn_last_beat_i,
  input  logic [$clog2(AXI_DATA_WIDTH/4):0] txn_lbn_i,
  input  logic                          txn_is_final_i,
  output logic                          w_valid_o,
  input  logic                          w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]     w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   w_strb_o,
  output logic                          w_last_o
`ifdef SEQUENTIAL_STORE_BEAT_CNT_EN
  ,
  output logic [31:0]                   beat_cnt_o
`endif
);
  localparam int unsigned BUF_NBS   = DLEN / 4 * NR_LANES;
  localparam int unsigned BUS_NBS   = AXI_DATA_WIDTH / 4;
  localparam int unsigned BNS       = $clog2(BUS_NBS);
  localparam int unsigned PW        = $clog2(BUF_NBS);
  localparam int unsigned BUS_BYTES = AXI_DATA_WIDTH / 8;

  typedef enum logic {S_IDLE, S_PACK} state_e;

  state_e                    state_q, state_d;
  logic                      hold_v_q;
  logic [BUF_NBS*4-1:0]      hold_nb_q;
  logic [BUF_NBS-1:0]        hold_en_q;
  logic [PW-1:0]             nb_ptr_q;
  logic [BNS:0]              bus_cnt_q;
  logic [AXI_DATA_WIDTH-1:0] asm_nb_q;
  logic [BUS_NBS-1:0]        asm_en_q;
  logic                      w_valid_q, w_last_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [BUS_BYTES-1:0]      w_strb_q;

  logic [BNS:0]              lower, upper, base, bus_v;
  logic [PW:0]               buf_v, bus_vw, n;
  logic                      start, commit, complete, release_e;
  logic [BUF_NBS*4-1:0]      src_nb;
  logic [BUF_NBS-1:0]        src_en;
  logic [AXI_DATA_WIDTH-1:0] sh_nb, new_nb, full_nb;
  logic [BUS_NBS-1:0]        sh_en, new_en, full_en;
  logic [BUS_BYTES-1:0]      strb_d;
  logic                      unused_bits;

  assign lower    = txn_is_head_i ? {1'b0, txn_addr_i[BNS-1:0]} : '0;
  assign upper    = txn_last_beat_i ? txn_lbn_i : (BNS+1)'(BUS_NBS);
  assign bus_v    = upper - lower - bus_cnt_q;
  assign base     = lower + bus_cnt_q;
  assign buf_v    = (PW+1)'(BUF_NBS) - {1'b0, nb_ptr_q};
  assign bus_vw   = (PW+1)'(bus_v);
  assign n        = bus_vw < buf_v ? bus_vw : buf_v;
  assign complete = bus_vw <= buf_v;

  assign start     = state_q == S_IDLE && txn_valid_i && meta_valid_i;
  assign commit    = state_q == S_PACK && hold_v_q && txn_valid_i && (!w_valid_q || w_ready_i);
  // The entry is given back once exhausted, or at the final beat even if nibbles remain.
  assign release_e = commit && (!complete || bus_vw == buf_v || txn_is_final_i);

  // Readies are forced low while reset is asserted, independent of input activity.
  assign rx_shfu_ready_o = rst_ni && (!hold_v_q || release_e);
  assign meta_ready_o    = rst_ni && start;
  assign txn_ready_o     = rst_ni && commit && complete;

  // Align entry nibble nb_ptr to bus nibble base, then keep only the n nibbles in flight.
  assign src_nb = hold_nb_q >> {nb_ptr_q, 2'b00};
  assign src_en = hold_en_q >> nb_ptr_q;
  assign sh_nb  = src_nb[AXI_DATA_WIDTH-1:0] << {base, 2'b00};
  assign sh_en  = src_en[BUS_NBS-1:0] << base;

  always_comb begin
    new_nb = '0;
    new_en = '0;
    for (int j = 0; j < int'(BUS_NBS); j++) begin
      new_en[j]        = sh_en[j] && j >= int'(base) && j < int'(base) + int'(n);
      new_nb[4*j +: 4] = new_en[j] ? sh_nb[4*j +: 4] : 4'h0;
    end
  end

  assign full_nb = asm_nb_q | new_nb;
  assign full_en = asm_en_q | new_en;

  always_comb begin
    strb_d = '0;
    for (int b = 0; b < int'(BUS_BYTES); b++) strb_d[b] = full_en[2*b] | full_en[2*b+1];
  end

  always_comb begin
    state_d = state_q;
    if (start) state_d = S_PACK;
    if (commit && complete && txn_is_final_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      hold_v_q  <= 1'b0;
      hold_nb_q <= '0;
      hold_en_q <= '0;
      nb_ptr_q  <= '0;
      bus_cnt_q <= '0;
      asm_nb_q  <= '0;
      asm_en_q  <= '0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (rx_shfu_valid_i && rx_shfu_ready_o) begin
        hold_v_q  <= 1'b1;
        hold_nb_q <= rx_shfu_nb_i;
        hold_en_q <= rx_shfu_en_i;
      end else if (release_e) begin
        hold_v_q <= 1'b0;
      end
      if (start) begin
        nb_ptr_q  <= meta_nb_ptr_i;
        bus_cnt_q <= '0;
      end else if (commit) begin
        nb_ptr_q  <= release_e ? '0 : nb_ptr_q + n[PW-1:0];
        bus_cnt_q <= complete ? '0 : bus_cnt_q + n[BNS:0];
        asm_nb_q  <= complete ? '0 : full_nb;
        asm_en_q  <= complete ? '0 : full_en;
      end
      if (commit && complete) begin
        w_valid_q <= 1'b1;
        w_data_q  <= full_nb;
        w_strb_q  <= strb_d;
        w_last_q  <= txn_last_beat_i;
      end else if (w_ready_i) begin
        w_valid_q <= 1'b0;
      end
    end
  end

  assign w_valid_o = w_valid_q;
  assign w_data_o  = w_data_q;
  assign w_strb_o  = w_strb_q;
  assign w_last_o  = w_last_q;

`ifdef SEQUENTIAL_STORE_BEAT_CNT_EN
  logic [31:0] beat_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) beat_cnt_q <= '0;
    else if (start) beat_cnt_q <= '0;
    else if (w_valid_q && w_ready_i) beat_cnt_q <= beat_cnt_q + 32'd1;
  end
  assign beat_cnt_o = beat_cnt_q;
`endif

  assign unused_bits = ^{txn_addr_i[AXI_ADDR_WIDTH-1:BNS], src_nb[BUF_NBS*4-1:AXI_DATA_WIDTH],
                         src_en[BUF_NBS-1:BUS_NBS]};

  // Bus bounds must fall on byte boundaries.
  odd_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    commit |-> !lower[0] && !upper[0])
    else $error("sequential_store: odd nibble bound lower=%0d upper=%0d", lower, upper);
endmodule

// File: tb/tb_sequential_store.sv
// tb_sequential_store: randomized scoreboard bench for sequential_store against a nibble-stream model.
module tb_sequential_store;
  typedef struct {logic [255:0] nb; logic [63:0] en;} entry_t;
  typedef struct {logic [63:0] addr; logic head, last, fin; logic [5:0] lbn;} txn_t;
  typedef struct {logic [127:0] data; logic [15:0] strb; logic last;} exp_t;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         rx_shfu_valid_i = 1'b0;
  logic         rx_shfu_ready_o;
  logic [255:0] rx_shfu_nb_i = '0;
  logic [63:0]  rx_shfu_en_i = '0;
  logic         meta_valid_i = 1'b0;
  logic         meta_ready_o;
  logic [5:0]   meta_nb_ptr_i = '0;
  logic         txn_valid_i = 1'b0;
  logic         txn_ready_o;
  logic [63:0]  txn_addr_i = '0;
  logic         txn_is_head_i = 1'b0;
  logic         txn_last_beat_i = 1'b0;
  logic [5:0]   txn_lbn_i = '0;
  logic         txn_is_final_i = 1'b0;
  logic         w_valid_o;
  logic         w_ready_i = 1'b0;
  logic [127:0] w_data_o;
  logic [15:0]  w_strb_o;
  logic         w_last_o;
`ifdef SEQUENTIAL_STORE_BEAT_CNT_EN
  logic [31:0]  beat_cnt_o;
`endif

  sequential_store dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_shfu_valid_i(rx_shfu_valid_i), .rx_shfu_ready_o(rx_shfu_ready_o),
    .rx_shfu_nb_i(rx_shfu_nb_i), .rx_shfu_en_i(rx_shfu_en_i),
    .meta_valid_i(meta_valid_i), .meta_ready_o(meta_ready_o), .meta_nb_ptr_i(meta_nb_ptr_i),
    .txn_valid_i(txn_valid_i), .txn_ready_o(txn_ready_o), .txn_addr_i(txn_addr_i),
    .txn_is_head_i(txn_is_head_i), .txn_last_beat_i(txn_last_beat_i), .txn_lbn_i(txn_lbn_i),
    .txn_is_final_i(txn_is_final_i),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .w_last_o(w_last_o)
`ifdef SEQUENTIAL_STORE_BEAT_CNT_EN
    , .beat_cnt_o(beat_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int     n_chk = 0;
  int     n_fail = 0;
  entry_t ent_q[$];
  txn_t   txn_q[$];
  exp_t   bx_q[$];
  int     ptr_q[$];
  exp_t   sb_q[$];
  bit     mon_en = 1'b1;
  bit     wr_force1 = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: the request is one nibble stream (entries concatenated, starting at ptr);
  // each beat takes upper-lower nibbles from it and places them at bus nibble lower.
  task automatic build_req(input int ptr, input int nbeats, input int lo, input int lbn, input bit allen);
    entry_t ents[$];
    entry_t e;
    txn_t   t;
    exp_t   x;
    int     total, nent, s, l, u;
    total = 0;
    for (int k = 0; k < nbeats; k++) total += (k == nbeats - 1 ? lbn : 32) - (k == 0 ? lo : 0);
    nent = (ptr + total + 63) / 64;
    for (int i = 0; i < nent; i++) begin
      for (int w = 0; w < 8; w++) e.nb[32*w +: 32] = $urandom;
      e.en = allen ? '1 : {$urandom, $urandom};
      ents.push_back(e);
      ent_q.push_back(e);
    end
    ptr_q.push_back(ptr);
    s = ptr;
    for (int k = 0; k < nbeats; k++) begin
      l = k == 0 ? lo : 0;
      u = k == nbeats - 1 ? lbn : 32;
      t.addr = {$urandom, $urandom};
      if (k == 0) t.addr[4:0] = 5'(lo);
      t.head = k == 0;
      t.last = k == nbeats - 1;
      t.fin  = t.last;
      t.lbn  = t.last ? 6'(lbn) : 6'($urandom_range(0, 32));
      x.data = '0;
      x.strb = '0;
      x.last = t.last;
      for (int j = l; j < u; j++) begin
        if (ents[s/64].en[s%64]) begin
          x.data[4*j +: 4] = ents[s/64].nb[4*(s%64) +: 4];
          x.strb[j/2] = 1'b1;
        end
        s++;
      end
      txn_q.push_back(t);
      bx_q.push_back(x);
    end
  endtask

  task automatic txn_drv();
    txn_t t;
    exp_t x;
    bit   th, mh, new_req;
    int   g;
    new_req = 1'b1;
    while (txn_q.size() > 0) begin
      t = txn_q.pop_front();
      x = bx_q.pop_front();
      txn_addr_i = t.addr;
      txn_is_head_i = t.head;
      txn_last_beat_i = t.last;
      txn_is_final_i = t.fin;
      txn_lbn_i = t.lbn;
      txn_valid_i = 1'b1;
      if (new_req) begin
        meta_valid_i = 1'b1;
        meta_nb_ptr_i = 6'(ptr_q.pop_front());
      end
      g = 0;
      do begin
        #4;
        th = txn_ready_o;
        mh = meta_valid_i && meta_ready_o;
        @(posedge clk_i);
        @(negedge clk_i);
        if (mh) meta_valid_i = 1'b0;
        g++;
      end while (!th && g < 2000);
      n_chk++;
      if (!th) begin
        n_fail++;
        $display("FAIL txn_timeout: got no txn_ready expected handshake");
        txn_q.delete();
      end else sb_q.push_back(x);
      new_req = t.fin;
      txn_valid_i = 1'b0;
      if ($urandom % 3 == 0) @(negedge clk_i);
    end
    txn_valid_i = 1'b0;
    meta_valid_i = 1'b0;
  endtask

  task automatic ent_drv();
    entry_t e;
    bit     h;
    int     g;
    while (ent_q.size() > 0) begin
      e = ent_q.pop_front();
      rx_shfu_nb_i = e.nb;
      rx_shfu_en_i = e.en;
      rx_shfu_valid_i = 1'b1;
      g = 0;
      do begin
        #4;
        h = rx_shfu_ready_o;
        @(posedge clk_i);
        @(negedge clk_i);
        g++;
      end while (!h && g < 2000);
      n_chk++;
      if (!h) begin
        n_fail++;
        $display("FAIL rx_timeout: got no rx_shfu_ready expected handshake");
        ent_q.delete();
      end
      rx_shfu_valid_i = 1'b0;
      if ($urandom % 3 == 0) @(negedge clk_i);
    end
    rx_shfu_valid_i = 1'b0;
  endtask

  // W ready: holds low 3 cycles on the first valid beat, then random (or forced high).
  initial begin
    int bp_cnt;
    bp_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (bp_cnt < 4 && w_valid_o && rst_ni) begin
        w_ready_i = bp_cnt == 3;
        bp_cnt++;
      end else w_ready_i = wr_force1 || ($urandom % 4 != 0);
    end
  end

  // Monitor: pops the scoreboard on every W handshake and checks stability under stall.
  initial begin
    exp_t         x;
    bit           stall;
    logic [127:0] sd;
    logic [15:0]  ss;
    logic         sl;
    stall = 1'b0;
    forever begin
      @(negedge clk_i);
      #4;
      if (mon_en && stall && w_valid_o) begin
        chk("hold_data", w_data_o, sd);
        chk("hold_strb", w_strb_o, ss);
        chk("hold_last", w_last_o, sl);
      end
      if (mon_en && w_valid_o && w_ready_i) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h expected no beat", w_data_o);
        end else begin
          x = sb_q.pop_front();
          chk("w_data", w_data_o, x.data);
          chk("w_strb", w_strb_o, x.strb);
          chk("w_last", w_last_o, x.last);
        end
      end
      stall = w_valid_o && !w_ready_i;
      sd = w_data_o;
      ss = w_strb_o;
      sl = w_last_o;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  nb, lo, lbn;
    bit  h;
    #12;
    chk("rst_w_valid", w_valid_o, 0);
    chk("rst_w_data", w_data_o, 0);
    chk("rst_w_strb", w_strb_o, 0);
    chk("rst_w_last", w_last_o, 0);
    chk("rst_rx_ready", rx_shfu_ready_o, 0);
    chk("rst_meta_ready", meta_ready_o, 0);
    chk("rst_txn_ready", txn_ready_o, 0);
    build_req(0, 2, 0, 32, 1'b1);
    build_req(0, 1, 4, 32, 1'b1);
    build_req(48, 2, 0, 32, 1'b1);
    build_req(0, 1, 0, 16, 1'b1);
    for (int r = 0; r < 40; r++) begin
      nb  = $urandom_range(1, 4);
      lo  = 2 * $urandom_range(0, 15);
      lbn = nb == 1 ? 2 * $urandom_range(lo / 2 + 1, 16) : 2 * $urandom_range(1, 16);
      build_req($urandom_range(0, 63), nb, lo, lbn, $urandom % 3 == 0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    fork
      txn_drv();
      ent_drv();
    join
    for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(negedge clk_i);
    chk("sb_drained", 128'(sb_q.size()), 0);
    chk("entries_left", 128'(ent_q.size()), 0);
    // Reset mid-burst after the first beat of a multi-beat request is accepted.
    @(negedge clk_i);
    mon_en = 1'b0;
    wr_force1 = 1'b1;
    rx_shfu_nb_i = {8{32'hA5A5_5A5A}};
    rx_shfu_en_i = '1;
    rx_shfu_valid_i = 1'b1;
    meta_nb_ptr_i = '0;
    meta_valid_i = 1'b1;
    txn_addr_i = '0;
    txn_is_head_i = 1'b1;
    txn_last_beat_i = 1'b0;
    txn_is_final_i = 1'b0;
    txn_lbn_i = '0;
    txn_valid_i = 1'b1;
    h = 1'b0;
    for (int i = 0; i < 30 && !h; i++) begin
      #4;
      h = w_valid_o && w_ready_i;
      @(posedge clk_i);
      if (!h) @(negedge clk_i);
    end
    chk("midburst_beat_seen", h, 1);
    #1;
`ifdef SEQUENTIAL_STORE_BEAT_CNT_EN
    chk("beat_cnt_one", beat_cnt_o, 1);
`endif
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_w_valid", w_valid_o, 0);
    chk("mid_rst_w_data", w_data_o, 0);
    chk("mid_rst_w_strb", w_strb_o, 0);
    chk("mid_rst_w_last", w_last_o, 0);
    chk("mid_rst_rx_ready", rx_shfu_ready_o, 0);
    chk("mid_rst_meta_ready", meta_ready_o, 0);
    chk("mid_rst_txn_ready", txn_ready_o, 0);
`ifdef SEQUENTIAL_STORE_BEAT_CNT_EN
    chk("mid_rst_beat_cnt", beat_cnt_o, 0);
`endif
    @(negedge clk_i);
    @(negedge clk_i);
    rx_shfu_valid_i = 1'b0;
    rst_ni = 1'b1;
    #4;
    chk("post_rst_idle_meta_ready", meta_ready_o, 1);
    chk("post_rst_w_valid", w_valid_o, 0);
    chk("post_rst_txn_ready", txn_ready_o, 0);
    @(negedge clk_i);
    meta_valid_i = 1'b0;
    txn_valid_i = 1'b0;
    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
